// File: rtl/card_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module   : card_dispenser_if
// Brief    : Card-request handshake, deck RAM port and hand-total bus.
// Revision : 1.0 - initial release
// ============================================================================
interface card_dispenser_if #(
  parameter int ADDR_W = 6
);
  logic              i_Clear;
  logic              i_Card2Player;
  logic              i_Card2Dealer;
  logic              o_CardOK;
  logic [ADDR_W-1:0] o_DeckAddr;
  logic [3:0]        i_DeckData;
  logic [5:0]        o_HandP;
  logic [5:0]        o_HandD;
  logic [3:0]        o_LastRank;
  logic              o_LastToDealer;
  logic              o_DeckWrapped;

  modport slave (
    input  i_Clear, i_Card2Player, i_Card2Dealer, i_DeckData,
    output o_CardOK, o_DeckAddr, o_HandP, o_HandD, o_LastRank,
           o_LastToDealer, o_DeckWrapped
  );

  modport master (
    output i_Clear, i_Card2Player, i_Card2Dealer, i_DeckData,
    input  o_CardOK, o_DeckAddr, o_HandP, o_HandD, o_LastRank,
           o_LastToDealer, o_DeckWrapped
  );
endinterface
`default_nettype wire

// File: rtl/card_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : card_dispenser
// Brief    : Deals deck cards into player/dealer hands with soft-ace handling.
// Revision : 1.0 - initial release
// ============================================================================
module card_dispenser #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  card_dispenser_if.slave   bus
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DECK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_to_dealer;
  logic [ADDR_W-1:0] r_ptr;
  logic [5:0]        r_hand_p;
  logic [5:0]        r_hand_d;
  logic [1:0]        r_soft_p;
  logic [1:0]        r_soft_d;
  logic [3:0]        r_last_rank;
  logic              r_last_to_dealer;
  logic              r_wrapped;
  logic              r_card_ok;

  logic [5:0] w_hand_cur;
  logic [1:0] w_soft_cur;
  logic [4:0] w_value;
  logic       w_ace_soft;
  logic [6:0] w_sum;
  logic [1:0] w_soft_next;
  logic [5:0] w_hand_next;

  // Next total for the targeted hand; only consumed in the ADD cycle.
  always_comb begin
    w_hand_cur  = r_to_dealer ? r_hand_d : r_hand_p;
    w_soft_cur  = r_to_dealer ? r_soft_d : r_soft_p;
    w_value     = 5'd10;
    w_ace_soft  = 1'b0;
    if (bus.i_DeckData == 4'd1) begin
      if (({1'b0, w_hand_cur} + 7'd11) <= 7'd21) begin
        w_value    = 5'd11;
        w_ace_soft = 1'b1;
      end else begin
        w_value    = 5'd1;
      end
    end else if (bus.i_DeckData >= 4'd2 && bus.i_DeckData <= 4'd10) begin
      w_value = {1'b0, bus.i_DeckData};
    end
    w_sum       = {1'b0, w_hand_cur} + {2'b00, w_value};
    w_soft_next = w_soft_cur + {1'b0, w_ace_soft};
    // At most one soft ace can exist, so a single demotion is enough.
    if (w_sum > 7'd21 && w_soft_next != 2'd0) begin
      w_sum       = w_sum - 7'd10;
      w_soft_next = w_soft_next - 2'd1;
    end
    w_hand_next = (w_sum > 7'd63) ? 6'd63 : w_sum[5:0];
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n || bus.i_Clear) begin
      r_state          <= S_IDLE;
      r_to_dealer      <= 1'b0;
      r_ptr            <= '0;
      r_hand_p         <= 6'd0;
      r_hand_d         <= 6'd0;
      r_soft_p         <= 2'd0;
      r_soft_d         <= 2'd0;
      r_last_rank      <= 4'd0;
      r_last_to_dealer <= 1'b0;
      r_wrapped        <= 1'b0;
      r_card_ok        <= 1'b0;
    end else begin
      r_card_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_Card2Player || bus.i_Card2Dealer) begin
            r_to_dealer <= !bus.i_Card2Player;
            r_state     <= S_READ;
          end
        end
        S_READ: r_state <= S_ADD;
        S_ADD: begin
          if (r_to_dealer) begin
            r_hand_d <= w_hand_next;
            r_soft_d <= w_soft_next;
          end else begin
            r_hand_p <= w_hand_next;
            r_soft_p <= w_soft_next;
          end
          if (r_ptr == c_LAST_ADDR) begin
            r_ptr     <= '0;
            r_wrapped <= 1'b1;
          end else begin
            r_ptr <= r_ptr + ADDR_W'(1);
          end
          r_last_rank      <= bus.i_DeckData;
          r_last_to_dealer <= r_to_dealer;
          r_card_ok        <= 1'b1;
          r_state          <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_CardOK       = r_card_ok;
  assign bus.o_DeckAddr     = r_ptr;
  assign bus.o_HandP        = r_hand_p;
  assign bus.o_HandD        = r_hand_d;
  assign bus.o_LastRank     = r_last_rank;
  assign bus.o_LastToDealer = r_last_to_dealer;
  assign bus.o_DeckWrapped  = r_wrapped;

endmodule
`default_nettype wire
